// File: rtl/writeback_stage_vec_if.sv
// Writeback stage bus: MEM-side instruction handshake plus register-file write handshake.
// The slave modport is the writeback stage; the master modport drives it.
interface writeback_stage_vec_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int PC_W   = 32,
    parameter int RD_W   = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                ResultSrcW;
    logic [PC_W-1:0]           PCPlus4W;
    logic [LANES*LANE_W-1:0]   ALU_ResultW;
    logic [LANES*LANE_W-1:0]   ReadDataW;
    logic [RD_W-1:0]           RdW;
    logic                      RegWriteW;
    logic [LANES-1:0]          LaneMaskW;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [LANES*LANE_W-1:0]   ResultW;
    logic [RD_W-1:0]           wb_rd;
    logic [LANES-1:0]          wb_lane_we;

    modport slave (
        input  in_valid, ResultSrcW, PCPlus4W, ALU_ResultW, ReadDataW,
               RdW, RegWriteW, LaneMaskW, wb_ready,
        output in_ready, wb_valid, ResultW, wb_rd, wb_lane_we
    );

    modport master (
        output in_valid, ResultSrcW, PCPlus4W, ALU_ResultW, ReadDataW,
               RdW, RegWriteW, LaneMaskW, wb_ready,
        input  in_ready, wb_valid, ResultW, wb_rd, wb_lane_we
    );
endinterface

// File: rtl/writeback_stage_vec.sv
// Vector writeback stage: per-lane result select, drop of non-writing instructions,
// and a DEPTH-entry FIFO that decouples MEM from register-file write-port stalls.
module writeback_stage_vec #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int PC_W   = 32,
    parameter int RD_W   = 5,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    writeback_stage_vec_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  drop_count
);
    localparam int DW    = LANES * LANE_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DW-1:0]     sel_data;
    logic [LANES-1:0]  eff_we;
    logic [LANE_W-1:0] lane_sel [LANES];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [15:0]       drop_q, drop_d;

    logic [DW-1:0]     data_mem [DEPTH];
    logic [RD_W-1:0]   rd_mem   [DEPTH];
    logic [LANES-1:0]  we_mem   [DEPTH];

    logic in_ready, wb_valid, accept, no_write, enq, deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane 0 is the only lane that can carry the return address.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] pc_lane;
        if (gi == 0) begin : g_pc
            assign pc_lane = LANE_W'(bus.PCPlus4W);
        end else begin : g_zero
            assign pc_lane = '0;
        end
        assign lane_sel[gi] =
            (bus.ResultSrcW == 2'b00) ? bus.ALU_ResultW[gi*LANE_W +: LANE_W] :
            (bus.ResultSrcW == 2'b01) ? bus.ReadDataW[gi*LANE_W +: LANE_W]   :
            (bus.ResultSrcW == 2'b10) ? pc_lane                              :
                                        bus.ALU_ResultW[LANE_W-1:0];
        assign sel_data[gi*LANE_W +: LANE_W] = lane_sel[gi];
    end

    assign eff_we = (bus.ResultSrcW == 2'b10) ? (bus.LaneMaskW & LANES'(1)) : bus.LaneMaskW;

    assign in_ready = (occ_q < OCC_W'(DEPTH));
    assign wb_valid = (occ_q != '0);

    always_comb begin
        accept   = bus.in_valid && in_ready;
        no_write = !bus.RegWriteW || (bus.RdW == '0) || (eff_we == '0);
        enq      = accept && !no_write;
        deq      = wb_valid && bus.wb_ready;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        drop_d   = drop_q;
        if (deq) head_d = ptr_inc(head_q);
        if (enq) tail_d = ptr_inc(tail_q);
        case ({enq, deq})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (accept && no_write && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
        end
    end

    // Entry storage is never reset; outputs are masked by wb_valid instead.
    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[tail_q] <= sel_data;
            rd_mem[tail_q]   <= bus.RdW;
            we_mem[tail_q]   <= eff_we;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wb_valid   = wb_valid;
    assign bus.ResultW    = wb_valid ? data_mem[head_q] : '0;
    assign bus.wb_rd      = wb_valid ? rd_mem[head_q]   : '0;
    assign bus.wb_lane_we = wb_valid ? we_mem[head_q]   : '0;
    assign occupancy      = occ_q;
    assign drop_count     = drop_q;
endmodule

// File: tb/tb_writeback_stage_vec.sv
// Randomised and directed bench for writeback_stage_vec against a queue-based reference model.
module tb_writeback_stage_vec;
    localparam int LANES = 4, LANE_W = 32, PC_W = 32, RD_W = 5, DEPTH = 2;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   rd;
        logic [3:0]   we;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]  occupancy;
    logic [15:0] drop_count;

    entry_t mq[$];
    int     m_drop = 0;
    int     errors = 0;
    int     checks = 0;

    writeback_stage_vec_if #(.LANES(LANES), .LANE_W(LANE_W), .PC_W(PC_W), .RD_W(RD_W)) bus ();

    writeback_stage_vec #(.LANES(LANES), .LANE_W(LANE_W), .PC_W(PC_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_result(input logic [1:0] src, input logic [31:0] pc,
                                                  input logic [127:0] alu, input logic [127:0] rdat);
        case (src)
            2'd0:    return alu;
            2'd1:    return rdat;
            2'd2:    return {96'd0, pc};
            default: return {4{alu[31:0]}};
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        bit v;
        v = (mq.size() > 0);
        check_val({tag, ".in_ready"},   bus.in_ready,   (mq.size() < DEPTH));
        check_val({tag, ".wb_valid"},   bus.wb_valid,   v);
        check_val({tag, ".ResultW"},    bus.ResultW,    v ? mq[0].data : 128'd0);
        check_val({tag, ".wb_rd"},      bus.wb_rd,      v ? mq[0].rd : 5'd0);
        check_val({tag, ".wb_lane_we"}, bus.wb_lane_we, v ? mq[0].we : 4'd0);
        check_val({tag, ".occupancy"},  occupancy,      mq.size());
        check_val({tag, ".drop_count"}, drop_count,     m_drop);
        $display("%s: valid=%0d rd=%0d we=%h occ=%0d drops=%0d data=%h", tag,
                 bus.wb_valid, bus.wb_rd, bus.wb_lane_we, occupancy, drop_count, bus.ResultW);
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input bit v, input logic [1:0] src, input logic [31:0] pc,
                        input logic [127:0] alu, input logic [127:0] rdat, input logic [4:0] rd,
                        input bit rw, input logic [3:0] mask, input bit rdy);
        bit acc, dq;
        logic [3:0] ew;
        entry_t e;
        bus.in_valid = v;  bus.ResultSrcW = src; bus.PCPlus4W = pc;
        bus.ALU_ResultW = alu; bus.ReadDataW = rdat; bus.RdW = rd;
        bus.RegWriteW = rw; bus.LaneMaskW = mask; bus.wb_ready = rdy;
        acc = v && (mq.size() < DEPTH);
        dq  = (mq.size() > 0) && rdy;
        ew  = (src == 2'd2) ? (mask & 4'h1) : mask;
        if (dq) void'(mq.pop_front());
        if (acc) begin
            if (!rw || rd == 0 || ew == 0) begin
                if (m_drop < 16'hFFFF) m_drop++;
            end else begin
                e.data = model_result(src, pc, alu, rdat);
                e.rd = rd;
                e.we = ew;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, 2'd0, 32'd0, 128'd0, 128'd0, 5'd0, 1'b0, 4'd0, rdy);
    endtask

    initial begin
        bus.in_valid = 0; bus.ResultSrcW = 0; bus.PCPlus4W = 0; bus.ALU_ResultW = 0;
        bus.ReadDataW = 0; bus.RdW = 0; bus.RegWriteW = 0; bus.LaneMaskW = 0; bus.wb_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_outputs("reset");

        // Single ALU op, one-cycle latency, then empty again.
        step("alu", 1, 2'd0, 32'd0, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 128'd0, 5'd3, 1, 4'hF, 1);
        check_val("alu.explicit_valid", bus.wb_valid, 1'b1);
        check_val("alu.explicit_data", bus.ResultW, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        idle("alu_drain", 1);
        check_val("alu.explicit_empty", bus.wb_valid, 1'b0);

        step("pc", 1, 2'd2, 32'h0000_0104, 128'hFFFF, 128'd0, 5'd1, 1, 4'hF, 1);
        check_val("pc.explicit_we", bus.wb_lane_we, 4'h1);
        check_val("pc.explicit_data", bus.ResultW, 128'h104);
        step("bcast", 1, 2'd3, 32'd0, {96'h1234_5678_9ABC_DEF0_1357_9BDF, 32'hDEAD_BEEF}, 128'd0, 5'd7, 1, 4'h5, 1);
        check_val("bcast.explicit_data", bus.ResultW, {4{32'hDEAD_BEEF}});
        check_val("bcast.explicit_we", bus.wb_lane_we, 4'h5);
        step("load", 1, 2'd1, 32'd0, 128'd0, 128'hCAFE_0000_BEEF_0000_F00D_0000_ABCD_0123, 5'd9, 1, 4'hA, 1);
        idle("load_drain", 1);

        // Backpressure: third write must wait for a free slot.
        step("bp1", 1, 2'd0, 32'd0, 128'hA1, 128'd0, 5'd10, 1, 4'hF, 0);
        step("bp2", 1, 2'd0, 32'd0, 128'hA2, 128'd0, 5'd11, 1, 4'hF, 0);
        check_val("bp.explicit_full_ready", bus.in_ready, 1'b0);
        check_val("bp.explicit_full_occ", occupancy, 2'd2);
        step("bp3_blocked", 1, 2'd0, 32'd0, 128'hA3, 128'd0, 5'd12, 1, 4'hF, 0);
        step("bp3_release", 1, 2'd0, 32'd0, 128'hA3, 128'd0, 5'd12, 1, 4'hF, 1);
        check_val("bp.explicit_order", bus.wb_rd, 5'd11);
        step("bp3_accept", 1, 2'd0, 32'd0, 128'hA3, 128'd0, 5'd12, 1, 4'hF, 1);
        check_val("bp.explicit_third", bus.wb_rd, 5'd12);
        idle("bp_drain", 1);

        // Drops: each non-writing instruction is counted and never queued.
        step("drop_rd0", 1, 2'd0, 32'd0, 128'h5, 128'd0, 5'd0, 1, 4'hF, 1);
        step("drop_rw0", 1, 2'd0, 32'd0, 128'h6, 128'd0, 5'd4, 0, 4'hF, 1);
        step("drop_mask0", 1, 2'd0, 32'd0, 128'h7, 128'd0, 5'd4, 1, 4'h0, 1);
        check_val("drop.explicit_count", drop_count, 16'd3);
        check_val("drop.explicit_occ", occupancy, 2'd0);

        // Simultaneous enqueue and dequeue at occupancy 1.
        step("sim_fill", 1, 2'd0, 32'd0, 128'hB1, 128'd0, 5'd20, 1, 4'hF, 0);
        step("sim_both", 1, 2'd0, 32'd0, 128'hB2, 128'd0, 5'd21, 1, 4'hF, 1);
        check_val("sim.explicit_occ", occupancy, 2'd1);
        check_val("sim.explicit_head", bus.wb_rd, 5'd21);
        idle("sim_drain", 1);

        // Asynchronous reset while full and stalled.
        step("ar_fill1", 1, 2'd0, 32'd0, 128'hC1, 128'd0, 5'd30, 1, 4'hF, 0);
        step("ar_fill2", 1, 2'd0, 32'd0, 128'hC2, 128'd0, 5'd31, 1, 4'hF, 0);
        bus.in_valid = 0;
        #2 rst = 1'b0;
        #1;
        check_val("areset.wb_valid", bus.wb_valid, 1'b0);
        check_val("areset.occupancy", occupancy, 2'd0);
        check_val("areset.drop_count", drop_count, 16'd0);
        check_val("areset.ResultW", bus.ResultW, 128'd0);
        mq.delete();
        m_drop = 0;
        #2 rst = 1'b1;
        idle("areset_release", 0);
        check_val("areset.explicit_ready", bus.in_ready, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [127:0] alu, rdat;
            alu  = {$urandom, $urandom, $urandom, $urandom};
            rdat = {$urandom, $urandom, $urandom, $urandom};
            step($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
                 alu, rdat, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 3; i++) idle("final_drain", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
